// File: rtl/demod_regs_pkg.sv
// Shared register map, field positions, channel control record and reset
// values for the multi-channel demodulator register bank.
package demod_regs_pkg;

   // Bus geometry and address field positions
   localparam int DATA_W        = 32;
   localparam int ADDR_W        = 12;
   localparam int ADDR_BASE_LSB = 8;
   localparam int ADDR_BASE_W   = 4;
   localparam int ADDR_CH_LSB   = 5;
   localparam int ADDR_CH_W     = 3;
   localparam int ADDR_RI_LSB   = 2;
   localparam int ADDR_RI_W     = 3;

   // Register indices within a channel window
   localparam logic [2:0] RI_CONTROL   = 3'd0;
   localparam logic [2:0] RI_DACSEL    = 3'd1;
   localparam logic [2:0] RI_FALSELOCK = 3'd2;
   localparam logic [2:0] RI_STATUS    = 3'd3;
   localparam logic [2:0] RI_AMTC      = 3'd4;
   localparam logic [2:0] RI_FSKDEV    = 3'd5;
   localparam logic [2:0] RI_EQCTRL    = 3'd6;
   localparam logic [2:0] RI_EQREF     = 3'd7;

   // Field positions and widths
   localparam int DEMOD_LSB   = 0;   localparam int DEMOD_W  = 4;
   localparam int BSYNC_LSB   = 16;  localparam int BSYNC_W  = 2;
   localparam int DAC0_LSB    = 0;
   localparam int DAC1_LSB    = 8;
   localparam int DAC2_LSB    = 16;  localparam int DAC_W    = 4;
   localparam int FL_ALPHA_LSB = 0;
   localparam int FL_THR_LSB  = 16;  localparam int FL_W     = 16;
   localparam int LOCK_LSB    = 0;
   localparam int STICKY_LSB  = 8;
   localparam int MASK_LSB    = 16;  localparam int LOCK_W   = 4;
   localparam int AMTC_LSB    = 0;   localparam int AMTC_W   = 5;
   localparam int FSK_LSB     = 0;   localparam int FSK_W    = 16;
   localparam int EQ_EN_BIT   = 0;
   localparam int EQ_WTRST_BIT = 1;
   localparam int EQ_STEP_LSB = 4;   localparam int STEP_W   = 3;
   localparam int EQREF_LSB   = 0;   localparam int EQREF_W  = 16;

   // One channel's double-buffered control fields
   typedef struct packed {
      logic [DEMOD_W-1:0] demod_mode;
      logic [BSYNC_W-1:0] bitsync_mode;
      logic [DAC_W-1:0]   dac0_sel;
      logic [DAC_W-1:0]   dac1_sel;
      logic [DAC_W-1:0]   dac2_sel;
      logic [FL_W-1:0]    fl_alpha;
      logic [FL_W-1:0]    fl_thresh;
      logic [AMTC_W-1:0]  am_tc;
      logic [STEP_W-1:0]  step_expo;
      logic               eq_enable;
      logic [EQREF_W-1:0] eq_ref;
   } chan_ctrl_t;

   // Reset values
   localparam chan_ctrl_t        CTRL_RST   = '0;
   localparam logic [LOCK_W-1:0] MASK_RST   = '0;
   localparam logic [LOCK_W-1:0] STICKY_RST = '0;

   // Byte-lane merge for a 16-bit field spanning two bus lanes
   function automatic logic [15:0] merge16(input logic [15:0] old_val,
                                           input logic [15:0] new_val,
                                           input logic [1:0]  be);
      merge16 = old_val;
      if (be[0]) merge16[7:0]  = new_val[7:0];
      if (be[1]) merge16[15:8] = new_val[15:8];
   endfunction

endpackage

// File: rtl/demod_chan_regs.sv
// One channel window: shadow/active control registers, sticky loss-of-lock
// capture with mask, equalizer weight-reset pulse and the register read mux.
module demod_chan_regs
   import demod_regs_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [2:0]        ri,
   input  logic [DATA_W-1:0] wdata,
   input  logic [3:0]        wr,
   input  logic              frame_strobe,
   input  logic [LOCK_W-1:0] lock_in,
   input  logic [FSK_W-1:0]  fsk_dev,
   output chan_ctrl_t        active,
   output logic              wt_reset,
   output logic              irq_req,
   output logic [DATA_W-1:0] rd_data
);

   chan_ctrl_t        shadow;
   logic [LOCK_W-1:0] lock_prev;
   logic [LOCK_W-1:0] sticky;
   logic [LOCK_W-1:0] mask;
   logic [LOCK_W-1:0] lock_fall;
   logic [LOCK_W-1:0] w1c;
   logic              status_we;

   assign status_we = we && (ri == RI_STATUS);
   assign lock_fall = lock_prev & ~lock_in;
   assign w1c       = (status_we && wr[1]) ? wdata[STICKY_LSB +: LOCK_W] : '0;
   assign irq_req   = |(sticky & mask);

   // Shadow registers: byte-lane writes from the bus
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow <= CTRL_RST;
      end else if (we) begin
         case (ri)
            RI_CONTROL: begin
               if (wr[0]) shadow.demod_mode   <= wdata[DEMOD_LSB +: DEMOD_W];
               if (wr[2]) shadow.bitsync_mode <= wdata[BSYNC_LSB +: BSYNC_W];
            end
            RI_DACSEL: begin
               if (wr[0]) shadow.dac0_sel <= wdata[DAC0_LSB +: DAC_W];
               if (wr[1]) shadow.dac1_sel <= wdata[DAC1_LSB +: DAC_W];
               if (wr[2]) shadow.dac2_sel <= wdata[DAC2_LSB +: DAC_W];
            end
            RI_FALSELOCK: begin
               shadow.fl_alpha  <= merge16(shadow.fl_alpha, wdata[FL_ALPHA_LSB +: FL_W], wr[1:0]);
               shadow.fl_thresh <= merge16(shadow.fl_thresh, wdata[FL_THR_LSB +: FL_W], wr[3:2]);
            end
            RI_AMTC: begin
               if (wr[0]) shadow.am_tc <= wdata[AMTC_LSB +: AMTC_W];
            end
            RI_EQCTRL: begin
               if (wr[0]) begin
                  shadow.eq_enable <= wdata[EQ_EN_BIT];
                  shadow.step_expo <= wdata[EQ_STEP_LSB +: STEP_W];
               end
            end
            RI_EQREF: begin
               shadow.eq_ref <= merge16(shadow.eq_ref, wdata[EQREF_LSB +: EQREF_W], wr[1:0]);
            end
            default: ;
         endcase
      end
   end

   // Active registers: whole channel loads from shadow on the frame strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         active <= CTRL_RST;
      end else if (frame_strobe) begin
         active <= shadow;
      end
   end

   // Lock history, sticky capture (set beats clear), mask and weight-reset pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         lock_prev <= '0;
         sticky    <= STICKY_RST;
         mask      <= MASK_RST;
         wt_reset  <= 1'b0;
      end else begin
         lock_prev <= lock_in;
         sticky    <= (sticky & ~w1c) | lock_fall;
         if (status_we && wr[2]) mask <= wdata[MASK_LSB +: LOCK_W];
         wt_reset  <= we && (ri == RI_EQCTRL) && wr[0] && wdata[EQ_WTRST_BIT];
      end
   end

   // Read image of the addressed register (shadow values, live status)
   // NOTE: the output is defaulted before the case so no path leaves it unassigned (no latch).
   always_comb begin
      rd_data = '0;
      case (ri)
         RI_CONTROL: begin
            rd_data[DEMOD_LSB +: DEMOD_W] = shadow.demod_mode;
            rd_data[BSYNC_LSB +: BSYNC_W] = shadow.bitsync_mode;
         end
         RI_DACSEL: begin
            rd_data[DAC0_LSB +: DAC_W] = shadow.dac0_sel;
            rd_data[DAC1_LSB +: DAC_W] = shadow.dac1_sel;
            rd_data[DAC2_LSB +: DAC_W] = shadow.dac2_sel;
         end
         RI_FALSELOCK: rd_data = {shadow.fl_thresh, shadow.fl_alpha};
         RI_STATUS: begin
            rd_data[LOCK_LSB +: LOCK_W]   = lock_in;
            rd_data[STICKY_LSB +: LOCK_W] = sticky;
            rd_data[MASK_LSB +: LOCK_W]   = mask;
         end
         RI_AMTC:   rd_data[AMTC_LSB +: AMTC_W] = shadow.am_tc;
         RI_FSKDEV: rd_data[FSK_LSB +: FSK_W]   = fsk_dev;
         RI_EQCTRL: begin
            rd_data[EQ_EN_BIT]                = shadow.eq_enable;
            rd_data[EQ_STEP_LSB +: STEP_W]    = shadow.step_expo;
         end
         RI_EQREF:  rd_data[EQREF_LSB +: EQREF_W] = shadow.eq_ref;
         default: ;
      endcase
   end

endmodule

// File: rtl/demod_reg_bank.sv
// Multi-channel demodulator register bank: bus decode, per-channel register
// windows, registered read data and the combined loss-of-lock interrupt.
module demod_reg_bank
   import demod_regs_pkg::*;
#(
   parameter int         NCH  = 2,
   parameter logic [3:0] BASE = 4'h0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   dataIn,
   input  logic                cs,
   input  logic [3:0]          wr,
   output logic [DATA_W-1:0]   dataOut,
   input  logic                frameStrobe,
   input  logic [4*NCH-1:0]    lockIn,
   input  logic [16*NCH-1:0]   fskDeviation,
   output logic [4*NCH-1:0]    demodMode,
   output logic [2*NCH-1:0]    bitsyncMode,
   output logic [4*NCH-1:0]    dac0Select,
   output logic [4*NCH-1:0]    dac1Select,
   output logic [4*NCH-1:0]    dac2Select,
   output logic [16*NCH-1:0]   falseLockAlpha,
   output logic [16*NCH-1:0]   falseLockThreshold,
   output logic [5*NCH-1:0]    amTC,
   output logic [3*NCH-1:0]    cma_stepExpo,
   output logic [NCH-1:0]      cma_enable,
   output logic [16*NCH-1:0]   cma_refLevel,
   output logic [NCH-1:0]      cma_wtReset,
   output logic                irq
);

   logic [ADDR_CH_W-1:0] ch;
   logic [ADDR_RI_W-1:0] ri;
   logic                 base_ok;
   logic                 ch_ok;
   logic                 hit;
   logic                 unused_addr_lsbs;
   logic [NCH-1:0]       chan_we;
   logic [NCH-1:0]       irq_vec;
   logic [DATA_W-1:0]    chan_rd [NCH];
   logic [DATA_W-1:0]    rd_mux;
   chan_ctrl_t           act [NCH];

   assign ch      = addr[ADDR_CH_LSB +: ADDR_CH_W];
   assign ri      = addr[ADDR_RI_LSB +: ADDR_RI_W];
   assign base_ok = cs && (addr[ADDR_BASE_LSB +: ADDR_BASE_W] == BASE);
   assign ch_ok   = ({29'd0, ch} < 32'(NCH));
   assign hit     = base_ok && ch_ok && (|wr);
   assign unused_addr_lsbs = ^addr[1:0];

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      assign chan_we[g] = hit && (ch == 3'(g));

      demod_chan_regs u_chan (
         .clk          (clk),
         .reset        (reset),
         .we           (chan_we[g]),
         .ri           (ri),
         .wdata        (dataIn),
         .wr           (wr),
         .frame_strobe (frameStrobe),
         .lock_in      (lockIn[4*g +: 4]),
         .fsk_dev      (fskDeviation[16*g +: 16]),
         .active       (act[g]),
         .wt_reset     (cma_wtReset[g]),
         .irq_req      (irq_vec[g]),
         .rd_data      (chan_rd[g])
      );

      assign demodMode[4*g +: 4]           = act[g].demod_mode;
      assign bitsyncMode[2*g +: 2]         = act[g].bitsync_mode;
      assign dac0Select[4*g +: 4]          = act[g].dac0_sel;
      assign dac1Select[4*g +: 4]          = act[g].dac1_sel;
      assign dac2Select[4*g +: 4]          = act[g].dac2_sel;
      assign falseLockAlpha[16*g +: 16]    = act[g].fl_alpha;
      assign falseLockThreshold[16*g +: 16] = act[g].fl_thresh;
      assign amTC[5*g +: 5]                = act[g].am_tc;
      assign cma_stepExpo[3*g +: 3]        = act[g].step_expo;
      assign cma_enable[g]                 = act[g].eq_enable;
      assign cma_refLevel[16*g +: 16]      = act[g].eq_ref;
   end

   // Channel read mux: channels at or above NCH never match and read 0
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NCH; i++) begin
         if (ch == 3'(i)) rd_mux = chan_rd[i];
      end
   end

   // Registered read data, held between read cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         dataOut <= '0;
      end else if (cs && (wr == 4'h0)) begin
         dataOut <= base_ok ? rd_mux : '0;
      end
   end

   // Combined interrupt over all channels
   always_ff @(posedge clk) begin
      if (reset) irq <= 1'b0;
      else       irq <= |irq_vec;
   end

endmodule

// File: doc/demod_reg_bank.md
# demod_reg_bank

Clocked, multi-channel successor to the demodulator control/status register bank. It decodes a 32-bit microprocessor bus with byte write enables into `NCH` identical channel register windows. Control writes are double-buffered so that a channel's active outputs change only on a frame strobe. Per-channel lock status gets sticky loss-of-lock capture, a mask, and a single combined interrupt. It sits between the bus interface and the per-channel demod, bitsync and CMA-equalizer datapaths.

## Interface
Parameters:
- `NCH`, default 2: number of channels, 1..8.
- `BASE`, default 4'h0: value that `addr[11:8]` must equal for the bank to be selected.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  12  byte address. Fields: `[11:8]` = BASE, `[7:5]` = channel, `[4:2]` = register index.
- `dataIn`  in  32  write data.
- `cs`  in  1  bank select.
- `wr`  in  4  byte write enables; `wr[n]` covers `dataIn[8n+7:8n]`.
- `dataOut`  out  32  registered read data.
- `frameStrobe`  in  1  one-cycle pulse that transfers shadow registers to active registers for all channels.
- `lockIn`  in  4·NCH  per channel `{auBitsyncLock, highFreqOffset, bitsyncLock, demodLock}`.
- `fskDeviation`  in  16·NCH  live, read-only.
- `demodMode` out 4·NCH, `bitsyncMode` out 2·NCH, `dac0Select`/`dac1Select`/`dac2Select` out 4·NCH each, `falseLockAlpha`/`falseLockThreshold` out 16·NCH each, `amTC` out 5·NCH, `cma_stepExpo` out 3·NCH, `cma_enable` out NCH, `cma_refLevel` out 16·NCH: all active (post-strobe) values.
- `cma_wtReset`  out  NCH  one-cycle pulse per channel.
- `irq`  out  1  OR over channels of `(sticky & mask)`.

## Operation
- Write hit: `cs & (addr[11:8]==BASE) & (channel<NCH) & |wr`. A write to a channel at or above NCH is ignored and reads back 0.
- Register index map, with fields at the same bit positions as the previous-generation bank:
  - 0 CONTROL: `demodMode[3:0]`, `bitsyncMode[17:16]`.
  - 1 DACSELECT: `[3:0]`, `[11:8]`, `[19:16]`.
  - 2 FALSELOCK: `{threshold[31:16], alpha[15:0]}`.
  - 3 STATUS: live lock `[3:0]` (RO), sticky `[11:8]` (write 1 to clear), mask `[19:16]` (RW).
  - 4 AMTC: `[4:0]`.
  - 5 FSKDEV: `[15:0]` (RO).
  - 6 EQ_CONTROL: `enable[0]`, `wtReset[1]` (write 1 → pulse, reads 0), `stepExpo[6:4]`.
  - 7 EQ_REF_LEVEL: `[15:0]`.
- Shadow registers:
  - Writes update shadow copies byte by byte, per `wr`.
  - Reads return shadow values, not active ones.
  - On `frameStrobe`, active ← shadow for every channel.
  - Mask, sticky and wtReset are not shadowed.
- Sticky bit k of a channel sets on a 1→0 transition of that channel's `lockIn` bit k, using a registered previous value. Set has priority over a same-cycle W1C.
- Unmapped bits, unmapped indices and non-matching BASE all read 0.

## Timing
- Write takes effect at the rising edge where the hit is true. An active output changes at the first `frameStrobe` edge strictly after that write edge. If a write and `frameStrobe` occur on the same edge, active takes the pre-write shadow.
- `cma_wtReset` is high for exactly the one cycle after the write edge, independent of `frameStrobe`.
- Read latency is 1: `dataOut` is registered from the `cs & ~|wr` cycle and holds its previous value when not reading. A STATUS read that coincides with a new sticky set returns the pre-set value.
- Sticky bits set one cycle after the `lockIn` fall. `irq` is registered and follows the sticky update by one cycle.
- Reset clears every shadow, active, sticky, mask and previous-lock register, `dataOut`, `irq` and `cma_wtReset` to 0. Reset wins over any concurrent write or strobe. The previous-lock registers load 0, so no sticky bit sets on the first cycle after reset.

## Structure
- Package `demod_regs_pkg` holds:
  - register index localparams (`RI_CONTROL` … `RI_EQREF`);
  - field bit positions and widths;
  - reset values;
  - the channel-field position constants.
- Sub-module `demod_chan_regs` implements one channel's shadow/active registers, sticky logic and read mux, and is instantiated through a generate loop. The top level handles decode, the channel read mux, the `dataOut` register and the `irq` OR.

## Test plan
- Write CONTROL ch1 = 32'h0002_0005 with `wr` = 4'hF, no strobe → `demodMode[7:4]` stays 0. Read returns 32'h0002_0005. Pulse `frameStrobe` → `demodMode[7:4]` = 5 and `bitsyncMode[3:2]` = 2 on the next cycle.
- FALSELOCK ch0 with `wr` = 4'h3, data 32'hAAAA_1234 → alpha = 16'h1234, threshold stays 0. Then `wr` = 4'hC → threshold = 16'hAAAA after strobe.
- Drop `lockIn[0]` 1→0, mask[16] = 1 → sticky[8] set and `irq` = 1 two cycles after the fall. W1C 32'h100 → `irq` = 0. A W1C on the same edge as a new fall leaves sticky = 1.
- Write EQ_CONTROL ch0 = 32'h2 → `cma_wtReset[0]` is high for exactly 1 cycle and reads back 0.
- Write to channel 3 with NCH = 2, and to a non-matching BASE → no outputs change, read = 0. Assert `reset` mid-burst → all outputs 0 next edge.
